// File: rtl/qmc_lsm_pkg.sv
// qmc_lsm_pkg: shared fixed-point types, driver states and path-memory sizing helper
package qmc_lsm_pkg;
    localparam int FX_W = 32;
    localparam int QINT = 16;
    localparam int QFRAC = FX_W - QINT;
    typedef logic [FX_W-1:0] fx_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} drv_state_t;
    function automatic int addr_w(input int n_paths, input int n_steps);
        return (n_paths * n_steps > 1) ? $clog2(n_paths * n_steps) : 1;
    endfunction
endpackage

// File: rtl/lsm_path_counter.sv
// lsm_path_counter: nested path (inner) / step (outer) counter with wrap and last flag
module lsm_path_counter #(
    parameter int N_P = 64,
    parameter int N_S = 16,
    parameter int PW = (N_P > 1) ? $clog2(N_P) : 1,
    parameter int KW = (N_S > 1) ? $clog2(N_S) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] p,
    output logic [KW-1:0] k,
    output logic          last
);
    logic [PW-1:0] p_q, p_d;
    logic [KW-1:0] k_q, k_d;
    logic p_last, k_last;
    always_comb begin
        p_last = p_q == PW'(N_P - 1);
        k_last = k_q == KW'(N_S - 1);
        p_d = clr ? '0 : !inc ? p_q : p_last ? '0 : p_q + 1'b1;
        k_d = clr ? '0 : !(inc && p_last) ? k_q : k_last ? '0 : k_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            k_q <= '0;
        end else begin
            p_q <= p_d;
            k_q <= k_d;
        end
    end
    assign p = p_q;
    assign k = k_q;
    assign last = p_last && k_last;
endmodule

// File: rtl/gbm_path_driver.sv
// gbm_path_driver: sequences N_PATHS x N_STEPS GBM steps and writes results to path memory.
// Optional antithetic pairing (z / -z per sample) enabled by defining GBM_ANTITHETIC_EN.
module gbm_path_driver import qmc_lsm_pkg::*; #(
    parameter int WIDTH = FX_W,
    parameter int N_PATHS = 64,
    parameter int N_STEPS = 16,
    parameter int ADDR_W = addr_w(N_PATHS, N_STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  s0,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              z_valid,
    output logic              z_ready,
    input  logic [WIDTH-1:0]  z_data,
    output logic              gbm_valid,
    output logic [WIDTH-1:0]  gbm_s,
    output logic [WIDTH-1:0]  gbm_z,
    input  logic              gbm_ret_valid,
    input  logic [WIDTH-1:0]  gbm_ret_s,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data
);
    localparam int PW = (N_PATHS > 1) ? $clog2(N_PATHS) : 1;
    localparam int KW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int OW = $clog2(N_PATHS + 1);
`ifdef GBM_ANTITHETIC_EN
    localparam int OUT_LIM = N_PATHS - 1;
`else
    localparam int OUT_LIM = N_PATHS;
`endif
    drv_state_t state_q, state_d;
    logic [OW-1:0] out_q, out_d;
    logic [WIDTH-1:0] s0_q, s0_d, gbm_s_q, gbm_s_d, gbm_z_q, gbm_z_d, wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic err_q, err_d, gbm_valid_q, gbm_valid_d, wr_en_q, wr_en_d;
    logic [WIDTH-1:0] cur_q [N_PATHS];
    logic [WIDTH-1:0] cur_d [N_PATHS];
    logic [PW-1:0] ip, rp;
    logic [KW-1:0] ik, rk;
    logic ilast, rlast, go, fire, issue, ret_ok, ret_bad;
    assign busy = state_q == RUN || state_q == DRAIN;
    assign done = state_q == DONE;
`ifdef GBM_ANTITHETIC_EN
    // odd paths ride on the previous even sample, so only even slots take a handshake
    assign z_ready = state_q == RUN && out_q < OW'(OUT_LIM) && !ip[0];
    assign issue = fire || (state_q == RUN && ip[0]);
`else
    assign z_ready = state_q == RUN && out_q < OW'(OUT_LIM);
    assign issue = fire;
`endif
    assign go = state_q == IDLE && start;
    assign fire = z_valid && z_ready;
    assign ret_ok = gbm_ret_valid && busy && out_q != '0;
    // the final return can only follow the final issue, so seeing it in RUN is bogus
    assign ret_bad = gbm_ret_valid && busy && (out_q == '0 || (rlast && state_q == RUN));
    lsm_path_counter #(.N_P(N_PATHS), .N_S(N_STEPS), .PW(PW), .KW(KW)) u_issue_cnt (
        .clk(clk), .rst(rst), .clr(go), .inc(issue), .p(ip), .k(ik), .last(ilast)
    );
    lsm_path_counter #(.N_P(N_PATHS), .N_S(N_STEPS), .PW(PW), .KW(KW)) u_ret_cnt (
        .clk(clk), .rst(rst), .clr(go), .inc(ret_ok), .p(rp), .k(rk), .last(rlast)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (issue && ilast) ? DRAIN : RUN;
            DRAIN:   state_d = (out_q == '0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        s0_d = go ? s0 : s0_q;
        err_d = go ? 1'b0 : err_q | ret_bad;
        out_d = out_q + OW'(issue) - OW'(ret_ok);
        gbm_valid_d = issue;
        gbm_s_d = !issue ? gbm_s_q : (ik == '0) ? s0_q : cur_q[ip];
        gbm_z_d = fire ? z_data : issue ? -gbm_z_q : gbm_z_q;
        wr_en_d = ret_ok;
        wr_addr_d = ret_ok ? ADDR_W'(rk) * ADDR_W'(N_PATHS) + ADDR_W'(rp) : wr_addr_q;
        wr_data_d = ret_ok ? gbm_ret_s : wr_data_q;
        cur_d = cur_q;
        if (ret_ok) cur_d[rp] = gbm_ret_s;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q <= '0;
            s0_q <= '0;
            err_q <= 1'b0;
            gbm_valid_q <= 1'b0;
            gbm_s_q <= '0;
            gbm_z_q <= '0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cur_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            out_q <= out_d;
            s0_q <= s0_d;
            err_q <= err_d;
            gbm_valid_q <= gbm_valid_d;
            gbm_s_q <= gbm_s_d;
            gbm_z_q <= gbm_z_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cur_q <= cur_d;
        end
    end
    assign err = err_q;
    assign gbm_valid = gbm_valid_q;
    assign gbm_s = gbm_s_q;
    assign gbm_z = gbm_z_q;
    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_gbm_path_driver.sv
// tb_gbm_path_driver: directed bench with a loopback GBM model (S_next = S + z) and path-memory monitor
`timescale 1ns/1ps
module tb_gbm_path_driver;
    localparam int NP = 4, NS = 3, W = 32, AW = 4;
    localparam logic [W-1:0] S0 = 32'h0064_0000;
    localparam logic [W-1:0] Z1 = 32'h0001_0000;
    localparam logic [W-1:0] Z2 = 32'h0002_0000;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, z_valid = 1'b0, spur = 1'b0, mon_clr = 1'b0;
    logic [W-1:0] s0 = '0, z_data = '0;
    logic busy, done, err, z_ready, gbm_valid, gbm_ret_valid, wr_en;
    logic [W-1:0] gbm_s, gbm_z, gbm_ret_s, wr_data;
    logic [AW-1:0] wr_addr;
    int compared = 0, mismatched = 0;
    int lat = 5, zmode = 0;
    logic pv [16];
    logic [W-1:0] pd [16];
    logic [W-1:0] mem [NP*NS];
    int wr_cnt, done_cnt, samples, issues;
    logic addr_bad, vbad, fire_pend, stall_seen;

    always #5 clk = ~clk;

    gbm_path_driver #(.WIDTH(W), .N_PATHS(NP), .N_STEPS(NS)) dut (
        .clk(clk), .rst(rst), .start(start), .s0(s0), .busy(busy), .done(done), .err(err),
        .z_valid(z_valid), .z_ready(z_ready), .z_data(z_data),
        .gbm_valid(gbm_valid), .gbm_s(gbm_s), .gbm_z(gbm_z),
        .gbm_ret_valid(gbm_ret_valid), .gbm_ret_s(gbm_ret_s),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    assign gbm_ret_valid = pv[lat] | spur;
    assign gbm_ret_s = pv[lat] ? pd[lat] : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        pv[0] <= gbm_valid;
        pd[0] <= gbm_s + gbm_z;
        for (int i = 1; i < 16; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt <= 0; done_cnt <= 0; samples <= 0; issues <= 0;
            addr_bad <= 1'b0; vbad <= 1'b0; fire_pend <= 1'b0; stall_seen <= 1'b0;
            for (int i = 0; i < NP*NS; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                if (wr_addr != AW'(wr_cnt)) addr_bad <= 1'b1;
                mem[wr_addr] <= wr_data;
                wr_cnt <= wr_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (gbm_valid != fire_pend) vbad <= 1'b1;
            fire_pend <= z_valid && z_ready;
            if (z_valid && z_ready) samples <= samples + 1;
            if (gbm_valid) issues <= issues + 1;
            if (busy && z_valid && !z_ready) stall_seen <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        z_valid = (zmode == 2) ? ~z_valid : (zmode == 1);
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic start_run(input int l, input int m, input logic [W-1:0] z);
        lat = l; zmode = m; z_data = z; s0 = S0;
        clr_mon();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 600) begin
            step();
            n++;
        end
        compared++;
        if (done_cnt == 0) begin
            mismatched++;
            $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", n);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        zmode = 0;
        repeat (20) step();
        compared += 8;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
        if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
        if (z_ready !== 1'b0) begin mismatched++; $display("FAIL reset_z_ready: got %b want 0", z_ready); end
        if (gbm_valid !== 1'b0) begin mismatched++; $display("FAIL reset_gbm_valid: got %b want 0", gbm_valid); end
        if (wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        if (gbm_s !== '0) begin mismatched++; $display("FAIL reset_gbm_s: got %h want 0", gbm_s); end
        if (wr_addr !== '0) begin mismatched++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        rst = 1'b0;
        step();
        compared++;
        if (busy !== 1'b0 || z_ready !== 1'b0) begin
            mismatched++; $display("FAIL idle_after_reset: busy=%b z_ready=%b want 0/0", busy, z_ready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] e;
        start_run(5, 1, Z1);
        wait_done();
        for (int k = 0; k < NS; k++) for (int p = 0; p < NP; p++) begin
            e = S0 + 32'(k + 1) * Z1;
            compared++;
            if (mem[k*NP+p] !== e) begin
                mismatched++; $display("FAIL basic_mem[%0d]: got %h want %h", k*NP+p, mem[k*NP+p], e);
            end
        end
        compared += 6;
        if (wr_cnt != NP*NS) begin mismatched++; $display("FAIL basic_writes: got %0d want %0d", wr_cnt, NP*NS); end
        if (addr_bad !== 1'b0) begin mismatched++; $display("FAIL basic_addr_order: got out-of-order want 0..11"); end
        if (done_cnt != 1) begin mismatched++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        if (err !== 1'b0) begin mismatched++; $display("FAIL basic_err: got %b want 0", err); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        if (samples != NP*NS) begin mismatched++; $display("FAIL basic_samples: got %0d want %0d", samples, NP*NS); end
    endtask

    task automatic test_long_latency();
        logic [W-1:0] e;
        start_run(8, 1, Z1);
        wait_done();
        for (int k = 0; k < NS; k++) for (int p = 0; p < NP; p++) begin
            e = S0 + 32'(k + 1) * Z1;
            compared++;
            if (mem[k*NP+p] !== e) begin
                mismatched++; $display("FAIL lat8_mem[%0d]: got %h want %h", k*NP+p, mem[k*NP+p], e);
            end
        end
        compared += 3;
        if (stall_seen !== 1'b1) begin mismatched++; $display("FAIL lat8_stall: got no z_ready drop want a drop"); end
        if (wr_cnt != NP*NS) begin mismatched++; $display("FAIL lat8_writes: got %0d want %0d", wr_cnt, NP*NS); end
        if (err !== 1'b0) begin mismatched++; $display("FAIL lat8_err: got %b want 0", err); end
    endtask

    task automatic test_toggle();
        logic [W-1:0] e;
        start_run(5, 2, Z1);
        wait_done();
        for (int k = 0; k < NS; k++) for (int p = 0; p < NP; p++) begin
            e = S0 + 32'(k + 1) * Z1;
            compared++;
            if (mem[k*NP+p] !== e) begin
                mismatched++; $display("FAIL toggle_mem[%0d]: got %h want %h", k*NP+p, mem[k*NP+p], e);
            end
        end
        compared += 2;
        if (vbad !== 1'b0) begin mismatched++; $display("FAIL toggle_gbm_valid: got valid not one cycle after fire want match"); end
        if (wr_cnt != NP*NS) begin mismatched++; $display("FAIL toggle_writes: got %0d want %0d", wr_cnt, NP*NS); end
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] e;
        int n = 0;
        start_run(5, 1, Z1);
        while (issues < 6 && n < 100) begin step(); n++; end
        compared++;
        if (issues < 6) begin mismatched++; $display("FAIL midrun_issue_timeout: got %0d issues want 6", issues); end
        rst = 1'b1; zmode = 0; z_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        compared++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            mismatched++; $display("FAIL midrun_abort: busy=%b wr_en=%b want 0/0", busy, wr_en);
        end
        clr_mon();
        repeat (20) step();
        compared += 2;
        if (wr_cnt != 0) begin mismatched++; $display("FAIL midrun_idle_writes: got %0d want 0", wr_cnt); end
        if (err !== 1'b0) begin mismatched++; $display("FAIL midrun_idle_err: got %b want 0", err); end
        start_run(5, 1, Z1);
        wait_done();
        for (int k = 0; k < NS; k++) for (int p = 0; p < NP; p++) begin
            e = S0 + 32'(k + 1) * Z1;
            compared++;
            if (mem[k*NP+p] !== e) begin
                mismatched++; $display("FAIL rerun_mem[%0d]: got %h want %h", k*NP+p, mem[k*NP+p], e);
            end
        end
        compared += 2;
        if (wr_cnt != NP*NS) begin mismatched++; $display("FAIL rerun_writes: got %0d want %0d", wr_cnt, NP*NS); end
        if (err !== 1'b0) begin mismatched++; $display("FAIL rerun_err: got %b want 0", err); end
    endtask

    task automatic test_spurious();
        start_run(5, 0, Z1);
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step(); step();
        compared += 3;
        if (err !== 1'b1) begin mismatched++; $display("FAIL spur_err: got %b want 1", err); end
        if (wr_cnt != 0) begin mismatched++; $display("FAIL spur_write: got %0d writes want 0", wr_cnt); end
        if (busy !== 1'b1) begin mismatched++; $display("FAIL spur_busy: got %b want 1", busy); end
        zmode = 1;
        wait_done();
        compared += 2;
        if (err !== 1'b1) begin mismatched++; $display("FAIL spur_err_held: got %b want 1", err); end
        if (mem[NP*NS-1] !== S0 + 32'(NS) * Z1) begin
            mismatched++; $display("FAIL spur_last_mem: got %h want %h", mem[NP*NS-1], S0 + 32'(NS) * Z1);
        end
        start_run(5, 1, Z1);
        compared++;
        if (err !== 1'b0) begin mismatched++; $display("FAIL spur_err_clear: got %b want 0", err); end
        wait_done();
    endtask

    task automatic test_antithetic();
        logic [W-1:0] e;
        start_run(5, 1, Z2);
        wait_done();
        for (int k = 0; k < NS; k++) for (int p = 0; p < NP; p++) begin
            e = (p % 2 == 0) ? S0 + 32'(k + 1) * Z2 : S0 - 32'(k + 1) * Z2;
            compared++;
            if (mem[k*NP+p] !== e) begin
                mismatched++; $display("FAIL anti_mem[%0d]: got %h want %h", k*NP+p, mem[k*NP+p], e);
            end
        end
        compared += 3;
        if (samples != NP*NS/2) begin mismatched++; $display("FAIL anti_samples: got %0d want %0d", samples, NP*NS/2); end
        if (wr_cnt != NP*NS) begin mismatched++; $display("FAIL anti_writes: got %0d want %0d", wr_cnt, NP*NS); end
        if (err !== 1'b0) begin mismatched++; $display("FAIL anti_err: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
`ifdef GBM_ANTITHETIC_EN
        test_antithetic();
`else
        test_basic();
        test_long_latency();
        test_toggle();
        test_reset_midrun();
        test_spurious();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
